// File: rtl/spi_master_n_if.sv
// Bundles the CPU-side request/status signals and the SPI pins of spi_master_n.
// master is the controller's view; slave is the CPU plus peripheral side.
interface spi_master_n_if #(
  parameter int DATA_W = 8,
  parameter int NCS    = 1
);
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;

  logic              start;
  logic [DATA_W-1:0] wdata;
  logic              dc;
  logic [CSW-1:0]    cs_sel;
  logic              cpol;
  logic              cpha;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NCS-1:0]    cs_;
  logic              dc_;

  modport master (
    input  start, wdata, dc, cs_sel, cpol, cpha, miso,
    output busy, done, rdata, sck, mosi, cs_, dc_
  );

  modport slave (
    output start, wdata, dc, cs_sel, cpol, cpha, miso,
    input  busy, done, rdata, sck, mosi, cs_, dc_
  );
endinterface

// File: rtl/spi_master_n.sv
// SPI master, all four modes, N chip selects; receive path only when SPI_MISO_EN is defined.
// busy for DIV*(2*DATA_W+2) cycles per frame; start is ignored while busy (no queueing).
module spi_master_n #(
  parameter int DATA_W = 8,
  parameter int DIV    = 25,
  parameter int NCS    = 1
) (
  input logic            clk,
  input logic            reset_,
  spi_master_n_if.master bus
);
  localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BITW = $clog2(2 * DATA_W + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANS, HOLD} state_t;

  state_t            state, state_d;
  logic [CNTW-1:0]   cnt2, cnt2_d;
  logic [BITW-1:0]   bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr, tx_sr_d;
  logic [CSW-1:0]    sel_q, sel_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              sck_q, sck_d, mosi_q, mosi_d;
  logic              dc_q, dc_d, done_q, done_d;
  logic              hp_end, leading, shift_edge, sample;
  logic [NCS-1:0]    cs_n;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      cnt2    <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      sel_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt2    <= cnt2_d;
      bit_cnt <= bit_cnt_d;
      tx_sr   <= tx_sr_d;
      sel_q   <= sel_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt2_d     = cnt2;
    bit_cnt_d  = bit_cnt;
    tx_sr_d    = tx_sr;
    sel_d      = sel_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    dc_d       = dc_q;
    done_d     = 1'b0;
    hp_end     = (cnt2 == CNT_LAST);
    // Toggle number bit_cnt+1 is odd (a leading edge) when bit_cnt is even.
    leading    = ~bit_cnt[0];
    shift_edge = cpha_q ? leading : ~leading;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d   = SETUP;
          cnt2_d    = '0;
          bit_cnt_d = '0;
          sel_d     = bus.cs_sel;
          cpol_d    = bus.cpol;
          cpha_d    = bus.cpha;
          dc_d      = bus.dc;
          sck_d     = bus.cpol;
          // CPHA=0 must present the MSB before the first (sampling) edge.
          if (bus.cpha) begin
            tx_sr_d = bus.wdata;
          end else begin
            mosi_d  = bus.wdata[DATA_W-1];
            tx_sr_d = {bus.wdata[DATA_W-2:0], 1'b0};
          end
        end
      end
      SETUP: begin
        cnt2_d = cnt2 + 1'b1;
        if (hp_end) begin
          cnt2_d  = '0;
          state_d = TRANS;
        end
      end
      TRANS: begin
        cnt2_d = cnt2 + 1'b1;
        if (hp_end) begin
          cnt2_d    = '0;
          sck_d     = ~sck_q;
          bit_cnt_d = bit_cnt + 1'b1;
          sample    = ~shift_edge;
          if (shift_edge && bit_cnt != BIT_LAST) begin
            mosi_d  = tx_sr[DATA_W-1];
            tx_sr_d = {tx_sr[DATA_W-2:0], 1'b0};
          end
          if (bit_cnt == BIT_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        cnt2_d = cnt2 + 1'b1;
        if (hp_end) begin
          cnt2_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An out-of-range cs_sel matches no bit, so the frame runs with every select high.
  always_comb begin
    cs_n = '1;
    if (state != IDLE) begin
      for (int i = 0; i < NCS; i++) begin
        if (sel_q == CSW'(i)) cs_n[i] = 1'b0;
      end
    end
  end

  assign bus.cs_  = cs_n;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.dc_  = dc_q;

`ifdef SPI_MISO_EN
  logic [DATA_W-1:0] rx_sr, rdata_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_sr   <= '0;
      rdata_q <= '0;
    end else begin
      if (sample) rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
      if (state == HOLD && hp_end) rdata_q <= rx_sr;
    end
  end

  assign bus.rdata = rdata_q;
`else
  logic [1:0] unused_rx;
  assign unused_rx = {bus.miso, sample};
  assign bus.rdata = '0;
`endif
endmodule
